// File: rtl/pipeline_stall_controller_pkg.sv
// Shared constants for the pipeline stall / cache refill controller.
// Holds the refill FSM encoding, the load result-source code and default line size.
package pipeline_stall_controller_pkg;

    localparam int unsigned WORD_SIZE          = 32;
    localparam int unsigned DEFAULT_LINE_BEATS = 4;
    localparam logic [1:0]  RESULT_SRC_LOAD    = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_REQ  = 3'd1,
        ST_I_FILL = 3'd2,
        ST_D_REQ  = 3'd3,
        ST_D_FILL = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/pipeline_stall_controller_hazard_detect.sv
// Load-use hazard detection: a load in Execute whose destination feeds Decode.
module pipeline_stall_controller_hazard_detect
    import pipeline_stall_controller_pkg::*;
(
    input  logic [4:0] Rs1DH,
    input  logic [4:0] Rs2DH,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    output logic       lw_stall
);

    // x0 is never a real dependency, so a load targeting it cannot stall.
    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1DH) || (RdE == Rs2DH));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard stall/flush generation plus the instruction/data cache-line refill FSM.
// All outputs are combinational from the current state and inputs.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned LINE_BEATS = DEFAULT_LINE_BEATS,
    parameter int unsigned BEAT_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        Rs1DH,
    input  logic [4:0]        Rs2DH,
    input  logic [4:0]        RdE,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              IMissF,
    input  logic              DMissM,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_is_data,
    input  logic              mem_resp_valid,
    output logic              fill_we,
    output logic [BEAT_W-1:0] fill_beat,
    output logic              fill_done,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic              lw_stall;
    logic              in_fill;
    logic              i_stall;
    logic              d_stall;
    logic              soft_stall;

    pipeline_stall_controller_hazard_detect hazard_detect (
        .Rs1DH      (Rs1DH),
        .Rs2DH      (Rs2DH),
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .lw_stall   (lw_stall)
    );

    // Refill sequencer: a started refill always runs to DONE; misses are sampled only in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (DMissM)      state <= ST_D_REQ;
                    else if (IMissF) state <= ST_I_REQ;
                end
                ST_I_REQ: if (mem_req_ready) state <= ST_I_FILL;
                ST_D_REQ: if (mem_req_ready) state <= ST_D_FILL;
                ST_I_FILL, ST_D_FILL: begin
                    if (mem_resp_valid) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= ST_DONE;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    assign in_fill         = (state == ST_I_FILL) || (state == ST_D_FILL);
    assign mem_req_valid   = (state == ST_I_REQ) || (state == ST_D_REQ);
    assign mem_req_is_data = (state == ST_D_REQ) || (state == ST_D_FILL);
    assign fill_we         = in_fill && mem_resp_valid;
    assign fill_beat       = beat;
    assign fill_done       = (state == ST_DONE);

    // Same-cycle miss stalls from IDLE; the data-miss term is masked while reset is held.
    assign i_stall = (state == ST_I_REQ) || (state == ST_I_FILL) ||
                     ((state == ST_IDLE) && IMissF && !DMissM);
    assign d_stall = (state == ST_D_REQ) || (state == ST_D_FILL) ||
                     ((state == ST_IDLE) && DMissM && !rst);

    assign soft_stall = lw_stall || i_stall;

    // A data miss freezes the whole pipe and overrides load-use and redirect handling.
    assign StallF = d_stall || (soft_stall && !PCSrcE);
    assign StallD = d_stall || soft_stall;
    assign StallE = d_stall;
    assign StallM = d_stall;
    assign FlushD = !d_stall && PCSrcE && !rst;
    assign FlushE = !d_stall && (soft_stall || PCSrcE);

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed table-driven bench for pipeline_stall_controller.
module tb_pipeline_stall_controller;

    // Expected-output packing: {StallF,StallD,StallE,StallM,FlushD,FlushE, req_valid,is_data,fill_we, fill_beat[1:0], fill_done}
    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  rsrc;
        logic        pcsrc;
        logic        imiss;
        logic        dmiss;
        logic        ready;
        logic        resp;
        logic [11:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1DH, Rs2DH, RdE;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, IMissF, DMissM, mem_req_ready, mem_resp_valid;
    logic       mem_req_valid, mem_req_is_data, fill_we, fill_done;
    logic [1:0] fill_beat;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE;

    int checks = 0;
    int fails  = 0;

    vec_t tbl[24];

    pipeline_stall_controller #(.LINE_BEATS(4), .BEAT_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .Rs1DH           (Rs1DH),
        .Rs2DH           (Rs2DH),
        .RdE             (RdE),
        .ResultSrcE      (ResultSrcE),
        .PCSrcE          (PCSrcE),
        .IMissF          (IMissF),
        .DMissM          (DMissM),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_is_data (mem_req_is_data),
        .mem_resp_valid  (mem_resp_valid),
        .fill_we         (fill_we),
        .fill_beat       (fill_beat),
        .fill_done       (fill_done),
        .StallF          (StallF),
        .StallD          (StallD),
        .StallE          (StallE),
        .StallM          (StallM),
        .FlushD          (FlushD),
        .FlushE          (FlushE)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [1:0] rsrc, input logic pcsrc, input logic imiss,
                                input logic dmiss, input logic ready, input logic resp,
                                input logic [11:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rsrc = rsrc; v.pcsrc = pcsrc;
        v.imiss = imiss; v.dmiss = dmiss; v.ready = ready; v.resp = resp; v.exp = exp;
        return v;
    endfunction

    function automatic logic [11:0] observed();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE,
                mem_req_valid, mem_req_is_data, fill_we, fill_beat, fill_done};
    endfunction

    task automatic compare(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = observed();
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b_%b_%b_%b expected %b_%b_%b_%b", name,
                     act[11:6], act[5:3], act[2:1], act[0], exp[11:6], exp[5:3], exp[2:1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then let the clock edge pass.
    task automatic step(input string name, input vec_t v);
        Rs1DH = v.rs1; Rs2DH = v.rs2; RdE = v.rd; ResultSrcE = v.rsrc; PCSrcE = v.pcsrc;
        IMissF = v.imiss; DMissM = v.dmiss; mem_req_ready = v.ready; mem_resp_valid = v.resp;
        @(negedge clk);
        compare(name, v.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a data miss and a redirect on the inputs.
        rst = 1'b1;
        Rs1DH = 5'd0; Rs2DH = 5'd0; RdE = 5'd0; ResultSrcE = 2'b00; PCSrcE = 1'b1;
        IMissF = 1'b0; DMissM = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        #12;
        compare("reset_outputs", 12'b000001_000_00_0);
        @(negedge clk);
        rst = 1'b0;
        PCSrcE = 1'b0; DMissM = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(posedge clk);
        #1;

        //            rs1    rs2    rd     rsrc   pc    im    dm    rdy   rsp   expected
        tbl[0]  = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'b000000_000_00_0);
        tbl[1]  = mk(5'd5,  5'd0,  5'd5,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'b110001_000_00_0);
        tbl[2]  = mk(5'd3,  5'd0,  5'd0,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'b000000_000_00_0);
        tbl[3]  = mk(5'd5,  5'd0,  5'd5,  2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'b010011_000_00_0);
        tbl[4]  = mk(5'd1,  5'd2,  5'd9,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'b000011_000_00_0);
        tbl[5]  = mk(5'd1,  5'd7,  5'd7,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'b110001_000_00_0);
        tbl[6]  = mk(5'd5,  5'd0,  5'd5,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'b000000_000_00_0);
        // Instruction miss: ready late, gapped beats, redirect mid-fill must not abort.
        tbl[7]  = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'b110001_000_00_0);
        tbl[8]  = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'b110001_100_00_0);
        tbl[9]  = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'b110001_100_00_0);
        tbl[10] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'b010011_001_00_0);
        tbl[11] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'b110001_000_01_0);
        tbl[12] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'b110001_001_01_0);
        tbl[13] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'b110001_000_10_0);
        tbl[14] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'b110001_001_10_0);
        tbl[15] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'b110001_001_11_0);
        tbl[16] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'b000000_000_00_1);
        tbl[17] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'b000000_000_00_0);
        // Data miss freezes the pipe even with load-use and redirect present.
        tbl[18] = mk(5'd5,  5'd0,  5'd5,  2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'b111100_000_00_0);
        tbl[19] = mk(5'd5,  5'd0,  5'd5,  2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'b111100_110_00_0);
        tbl[20] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'b111100_011_00_0);
        tbl[21] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'b111100_011_01_0);
        tbl[22] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'b111100_011_10_0);
        tbl[23] = mk(5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'b111100_011_11_0);

        for (int i = 0; i < 24; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end
        step("d_done",      mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'b000000_000_00_1));
        step("d_back_idle", mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'b000000_000_00_0));

        // Simultaneous misses: data line first, one IDLE cycle, then instruction line.
        step("both_idle",   mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'b111100_000_00_0));
        step("both_dreq",   mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'b111100_110_00_0));
        for (int b = 0; b < 4; b++) begin
            step($sformatf("both_dbeat%0d", b),
                 mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {9'b111100_011, 2'(b), 1'b0}));
        end
        step("both_ddone",  mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'b000000_000_00_1));
        step("both_idle2",  mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'b110001_000_00_0));
        step("both_ireq",   mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'b110001_100_00_0));
        for (int b = 0; b < 4; b++) begin
            step($sformatf("both_ibeat%0d", b),
                 mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {9'b110001_001, 2'(b), 1'b0}));
        end
        step("both_idone",  mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'b000000_000_00_1));
        step("both_end",    mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'b000000_000_00_0));

        // Reset mid data refill after beat 1, then a fresh miss restarts at beat 0.
        step("rst_idle",    mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'b111100_000_00_0));
        step("rst_dreq",    mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'b111100_110_00_0));
        step("rst_beat0",   mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'b111100_011_00_0));
        step("rst_beat1",   mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'b111100_011_01_0));
        rst = 1'b1;
        #1;
        compare("rst_async", 12'b000000_000_00_0);
        step("rst_held",    mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'b000000_000_00_0));
        rst = 1'b0;
        step("rst_resp_ign", mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'b000000_000_00_0));
        step("rst_still_idle", mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'b000000_000_00_0));
        step("rst_new_miss", mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'b111100_000_00_0));
        step("rst_new_req",  mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'b111100_110_00_0));
        step("rst_new_beat0", mk(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'b111100_011_00_0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
